// File: rtl/baccarat_dealer.sv
// Baccarat dealing controller: sequences player/banker cards from new_card,
// applies the third-card rules and exposes card registers, scores and result.
module baccarat_dealer (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       step,
    input  logic [3:0] new_card,
    output logic [3:0] pcard1,
    output logic [3:0] pcard2,
    output logic [3:0] pcard3,
    output logic [3:0] dcard1,
    output logic [3:0] dcard2,
    output logic [3:0] dcard3,
    output logic [3:0] pscore,
    output logic [3:0] dscore,
    output logic       player_win,
    output logic       dealer_win,
    output logic       done
);

    typedef enum logic [2:0] {
        S_P1, S_D1, S_P2, S_D2, S_EVAL, S_P3, S_D3, S_RESULT
    } state_t;

    state_t     r_state;
    logic [3:0] r_pcard1, r_pcard2, r_pcard3;
    logic [3:0] r_dcard1, r_dcard2, r_dcard3;

    logic [4:0] w_psum, w_dsum;
    logic [3:0] w_pscore, w_dscore, w_nv;
    logic       w_natural, w_bank_draw;

    // Face cards and the unused codes 14/15 all count as zero.
    function automatic logic [3:0] card_val(input logic [3:0] c);
        return (c > 4'd9) ? 4'd0 : c;
    endfunction

    function automatic logic [3:0] mod10(input logic [4:0] s);
        logic [4:0] r;
        if (s >= 5'd20)      r = s - 5'd20;
        else if (s >= 5'd10) r = s - 5'd10;
        else                 r = s;
        return r[3:0];
    endfunction

    assign w_psum = {1'b0, card_val(r_pcard1)} + {1'b0, card_val(r_pcard2)}
                  + {1'b0, card_val(r_pcard3)};
    assign w_dsum = {1'b0, card_val(r_dcard1)} + {1'b0, card_val(r_dcard2)}
                  + {1'b0, card_val(r_dcard3)};
    assign w_pscore  = mod10(w_psum);
    assign w_dscore  = mod10(w_dsum);
    assign w_natural = (w_pscore >= 4'd8) || (w_dscore >= 4'd8);

    // Banker's draw after the player's third card looks at the incoming card,
    // since pcard3 is only being written on this same edge.
    assign w_nv = card_val(new_card);
    always_comb begin
        w_bank_draw = 1'b0;
        case (w_dscore)
            4'd0, 4'd1, 4'd2: w_bank_draw = 1'b1;
            4'd3:             w_bank_draw = (w_nv != 4'd8);
            4'd4:             w_bank_draw = (w_nv >= 4'd2) && (w_nv <= 4'd7);
            4'd5:             w_bank_draw = (w_nv >= 4'd4) && (w_nv <= 4'd7);
            4'd6:             w_bank_draw = (w_nv >= 4'd6) && (w_nv <= 4'd7);
            default:          w_bank_draw = 1'b0;
        endcase
    end

    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            r_state  <= S_P1;
            r_pcard1 <= 4'd0;
            r_pcard2 <= 4'd0;
            r_pcard3 <= 4'd0;
            r_dcard1 <= 4'd0;
            r_dcard2 <= 4'd0;
            r_dcard3 <= 4'd0;
        end else if (step) begin
            case (r_state)
                S_P1: begin r_pcard1 <= new_card; r_state <= S_D1; end
                S_D1: begin r_dcard1 <= new_card; r_state <= S_P2; end
                S_P2: begin r_pcard2 <= new_card; r_state <= S_D2; end
                S_D2: begin r_dcard2 <= new_card; r_state <= S_EVAL; end
                S_EVAL: begin
                    if (w_natural)              r_state <= S_RESULT;
                    else if (w_pscore <= 4'd5)  r_state <= S_P3;
                    else if (w_dscore <= 4'd5)  r_state <= S_D3;
                    else                        r_state <= S_RESULT;
                end
                S_P3: begin
                    r_pcard3 <= new_card;
                    r_state  <= w_bank_draw ? S_D3 : S_RESULT;
                end
                S_D3:     begin r_dcard3 <= new_card; r_state <= S_RESULT; end
                S_RESULT: r_state <= S_RESULT;
                default:  r_state <= S_P1;
            endcase
        end
    end

    assign pcard1 = r_pcard1;
    assign pcard2 = r_pcard2;
    assign pcard3 = r_pcard3;
    assign dcard1 = r_dcard1;
    assign dcard2 = r_dcard2;
    assign dcard3 = r_dcard3;
    assign pscore = w_pscore;
    assign dscore = w_dscore;

    assign done       = (r_state == S_RESULT);
    assign player_win = done && (w_pscore >= w_dscore);
    assign dealer_win = done && (w_dscore >= w_pscore);

endmodule

// File: tb/tb_baccarat_dealer.sv
// Randomized self-checking bench for baccarat_dealer against a hand-level model.
module tb_baccarat_dealer;

    logic       slow_clock = 1'b0;
    logic       resetb;
    logic       step;
    logic [3:0] new_card;
    logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
    logic [3:0] pscore, dscore;
    logic       player_win, dealer_win, done;

    int n_cmp = 0;
    int n_err = 0;

    baccarat_dealer dut (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .step       (step),
        .new_card   (new_card),
        .pcard1     (pcard1),
        .pcard2     (pcard2),
        .pcard3     (pcard3),
        .dcard1     (dcard1),
        .dcard2     (dcard2),
        .dcard3     (dcard3),
        .pscore     (pscore),
        .dscore     (dscore),
        .player_win (player_win),
        .dealer_win (dealer_win),
        .done       (done)
    );

    always #5 slow_clock = ~slow_clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int cv(input int c);
        return (c > 9) ? 0 : c;
    endfunction

    // Banker third-card table, read straight from the rules of the game.
    function automatic bit banker_draws(input int d, input int v);
        if (d <= 2) return 1'b1;
        if (d == 3) return v != 8;
        if (d == 4) return v >= 2 && v <= 7;
        if (d == 5) return v >= 4 && v <= 7;
        if (d == 6) return v >= 6 && v <= 7;
        return 1'b0;
    endfunction

    function automatic logic [3:0] rnd_card();
        return 4'($urandom_range(1, 15));
    endfunction

    task automatic do_reset(input string tag);
        @(negedge slow_clock);
        resetb   = 1'b0;
        step     = 1'($urandom_range(0, 1));
        new_card = rnd_card();
        @(posedge slow_clock); #1;
        chk({tag, "_cards"}, {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3}, 0);
        chk({tag, "_scores"}, {pscore, dscore}, 0);
        chk({tag, "_flags"}, {done, player_win, dealer_win}, 0);
        @(negedge slow_clock);
        resetb = 1'b1;
        step   = 1'b0;
    endtask

    task automatic idle_cycle(input string tag, input bit exp_done);
        @(negedge slow_clock);
        step     = 1'b0;
        new_card = rnd_card();
        @(posedge slow_clock); #1;
        chk(tag, done, exp_done);
    endtask

    // Plays one hand from P1 (caller has reset). c0..c3 are the initial cards,
    // c4/c5 the candidates for whichever third cards get drawn.
    task automatic run_hand(input string tag, input int c0, input int c1, input int c2,
                            input int c3, input int c4, input int c5, input bit gaps);
        int pv, dv, p3, d3, n, pf, df;
        int feed[7];
        pv = (cv(c0) + cv(c2)) % 10;
        dv = (cv(c1) + cv(c3)) % 10;
        p3 = 0; d3 = 0;
        feed[0] = c0; feed[1] = c1; feed[2] = c2; feed[3] = c3;
        feed[4] = $urandom_range(1, 15); feed[5] = c4; feed[6] = c5;
        if (pv >= 8 || dv >= 8) n = 5;
        else if (pv <= 5) begin
            p3 = c4;
            if (banker_draws(dv, cv(c4))) begin d3 = c5; n = 7; end
            else n = 6;
        end else if (dv <= 5) begin d3 = c4; n = 6; end
        else n = 5;
        pf = (cv(c0) + cv(c2) + cv(p3)) % 10;
        df = (cv(c1) + cv(c3) + cv(d3)) % 10;

        for (int e = 0; e < n; e++) begin
            if (gaps) repeat ($urandom_range(0, 2)) idle_cycle({tag, "_gap_done"}, 1'b0);
            @(negedge slow_clock);
            step     = 1'b1;
            new_card = 4'(feed[e]);
            @(posedge slow_clock); #1;
            chk({tag, "_done_edge"}, done, (e == n - 1) ? 1 : 0);
        end
        chk({tag, "_pcards"}, {pcard1, pcard2, pcard3}, {4'(c0), 4'(c2), 4'(p3)});
        chk({tag, "_dcards"}, {dcard1, dcard2, dcard3}, {4'(c1), 4'(c3), 4'(d3)});
        chk({tag, "_pscore"}, pscore, pf);
        chk({tag, "_dscore"}, dscore, df);
        chk({tag, "_pwin"}, player_win, (pf >= df) ? 1 : 0);
        chk({tag, "_dwin"}, dealer_win, (df >= pf) ? 1 : 0);

        // RESULT is terminal: further steps change nothing.
        repeat (2) begin
            @(negedge slow_clock);
            step     = 1'b1;
            new_card = rnd_card();
            @(posedge slow_clock); #1;
            chk({tag, "_hold"}, {done, pcard3, dcard3}, {1'b1, 4'(p3), 4'(d3)});
        end
        @(negedge slow_clock);
        step = 1'b0;
    endtask

    initial begin
        resetb   = 1'b0;
        step     = 1'b0;
        new_card = 4'd0;
        repeat (2) @(posedge slow_clock);

        do_reset("rst0");
        run_hand("natural", 3, 4, 5, 2, 9, 9, 1'b0);
        do_reset("rst1");
        run_hand("b7stand", 2, 7, 1, 13, 4, 9, 1'b0);
        do_reset("rst2");
        run_hand("p6bdraw", 6, 1, 13, 2, 5, 9, 1'b0);
        do_reset("rst3");
        run_hand("b3p8", 1, 2, 1, 1, 8, 9, 1'b0);
        do_reset("rst4");
        run_hand("b3p7", 1, 2, 1, 1, 7, 6, 1'b0);
        do_reset("rst5");
        run_hand("faces", 10, 11, 12, 14, 3, 4, 1'b0);

        // Step gap after D1, then a reset arriving after P2.
        do_reset("rst6");
        for (int e = 0; e < 2; e++) begin
            @(negedge slow_clock);
            step     = 1'b1;
            new_card = 4'(e + 5);
            @(posedge slow_clock); #1;
        end
        repeat (3) begin
            idle_cycle("gap_done", 1'b0);
            chk("gap_cards", {pcard1, dcard1, pcard2}, {4'd5, 4'd6, 4'd0});
        end
        @(negedge slow_clock);
        step     = 1'b1;
        new_card = 4'd9;
        @(posedge slow_clock); #1;
        chk("gap_p2", pcard2, 9);
        do_reset("midrst");
        run_hand("fresh", 4, 3, 4, 3, 2, 2, 1'b0);

        for (int h = 0; h < 150; h++) begin
            do_reset("rrst");
            run_hand("rand", $urandom_range(1, 15), $urandom_range(1, 15),
                     $urandom_range(1, 15), $urandom_range(1, 15),
                     $urandom_range(1, 15), $urandom_range(1, 15), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
